// File: rtl/fft_axi_pkg.sv
// Shared definitions for the FFT peak detector: beat markers, FSM states and the complex-bin layout.
package fft_axi_pkg;

    localparam logic [1:0] BURST_MID   = 2'b00;
    localparam logic [1:0] BURST_FIRST = 2'b01;
    localparam logic [1:0] BURST_LAST  = 2'b10;
    localparam logic [1:0] BURST_ONLY  = 2'b11;

    localparam int CPLX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } pd_state_t;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_bin_t;

    // FIRST and ONLY are the two codes with bit 0 set; both open a new frame.
    function automatic logic is_frame_start(input logic [1:0] burst);
        return burst[0];
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |x|^2 pipeline: S1 squares re and im, S2 adds them. A tag rides alongside each valid.
module fft_mag_sq #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    output logic [2*DATA_W:0]        out_mag,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    logic signed [2*DATA_W-1:0] re_ext;
    logic signed [2*DATA_W-1:0] im_ext;
    logic signed [2*DATA_W-1:0] re_sq;
    logic signed [2*DATA_W-1:0] im_sq;
    logic [TAG_W-1:0]           s1_tag;
    logic                       s1_valid;

    assign re_ext = (2*DATA_W)'(in_re);
    assign im_ext = (2*DATA_W)'(in_im);
    assign busy   = s1_valid || out_valid;

    // Squares are never negative, so zero-extending them into the sum is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_sq     <= '0;
            im_sq     <= '0;
            s1_tag    <= '0;
            s1_valid  <= 1'b0;
            out_mag   <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            re_sq     <= re_ext * re_ext;
            im_sq     <= im_ext * im_ext;
            s1_tag    <= in_tag;
            s1_valid  <= in_valid;
            out_mag   <= {1'b0, re_sq} + {1'b0, im_sq};
            out_tag   <= s1_tag;
            out_valid <= s1_valid && !clear;
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Consumes one FFT frame per FIRST..LAST burst and reports the strongest bin in the search window.
// Handshake: a beat transfers on a rising edge with i_ARVALID && o_ARREADY; o_ARREADY is registered and low only in FLUSH.
module fft_peak_detector
    import fft_axi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 12,
    parameter bit SKIP_DC   = 1'b1,
    parameter bit HALF_SPEC = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [2*DATA_W-1:0] i_ARDATA,
    input  logic                i_ARVALID,
    output logic                o_ARREADY,
    input  logic [1:0]          i_ARBURST,
    input  logic [IDX_W-1:0]    i_SAMPLES_NUMBER,
    output logic [IDX_W-1:0]    o_PEAK_INDEX,
    output logic [2*DATA_W:0]   o_PEAK_MAG,
    output logic                o_DONE,
    output logic                o_ERR,
    output logic                o_BUSY,
    output pd_state_t           o_dbg_state
);

    pd_state_t         state;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  bin_cnt;
    logic [IDX_W-1:0]  pk_idx;
    logic [2*DATA_W:0] pk_mag;
    logic              peak_stage_v;

    logic              accept;
    logic              start;
    logic              frame_beat;
    logic              elig;
    logic [IDX_W-1:0]  n_field;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  n_last;
    logic [IDX_W:0]    half_n;

    logic              ms_valid;
    logic [2*DATA_W:0] ms_mag;
    logic [IDX_W:0]    ms_tag;
    logic              pipe_busy;

    assign accept     = i_ARVALID && o_ARREADY;
    assign start      = accept && is_frame_start(i_ARBURST);
    assign frame_beat = start || (accept && state == RECV);
    assign n_field    = start ? i_SAMPLES_NUMBER : n_q;
    assign beat_idx   = start ? '0 : bin_cnt;
    assign n_last     = n_q - IDX_W'(1);
    // A zero length field means 2**IDX_W bins, so N/2 needs one extra bit.
    assign half_n     = {(n_field == '0), n_field[IDX_W-1:1]};
    assign elig       = (!SKIP_DC || beat_idx != '0) &&
                        (!HALF_SPEC || {1'b0, beat_idx} < half_n);
    assign o_dbg_state = state;

    fft_mag_sq #(
        .DATA_W(DATA_W),
        .TAG_W (IDX_W + 1)
    ) u_mag_sq (
        .clk      (i_clk),
        .rst_n    (i_rstn),
        .clear    (start),
        .in_valid (frame_beat),
        .in_re    (i_ARDATA[2*DATA_W-1:DATA_W]),
        .in_im    (i_ARDATA[DATA_W-1:0]),
        .in_tag   ({elig, beat_idx}),
        .out_valid(ms_valid),
        .out_mag  (ms_mag),
        .out_tag  (ms_tag),
        .busy     (pipe_busy)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            n_q          <= '0;
            bin_cnt      <= '0;
            pk_idx       <= '0;
            pk_mag       <= '0;
            peak_stage_v <= 1'b0;
            o_ARREADY    <= 1'b0;
            o_PEAK_INDEX <= '0;
            o_PEAK_MAG   <= '0;
            o_DONE       <= 1'b0;
            o_ERR        <= 1'b0;
            o_BUSY       <= 1'b0;
        end else begin
            o_DONE       <= 1'b0;
            peak_stage_v <= ms_valid;
            // Strict compare keeps the earliest (lowest-index) bin on ties.
            if (ms_valid && ms_tag[IDX_W] && ms_mag > pk_mag) begin
                pk_mag <= ms_mag;
                pk_idx <= ms_tag[IDX_W-1:0];
            end
            if (start) begin
                n_q          <= i_SAMPLES_NUMBER;
                bin_cnt      <= IDX_W'(1);
                pk_mag       <= '0;
                pk_idx       <= '0;
                o_PEAK_INDEX <= '0;
                o_PEAK_MAG   <= '0;
                o_BUSY       <= 1'b1;
                if (i_ARBURST == BURST_ONLY) begin
                    o_ERR     <= (state == RECV) || (i_SAMPLES_NUMBER != IDX_W'(1));
                    state     <= FLUSH;
                    o_ARREADY <= 1'b0;
                end else if (i_SAMPLES_NUMBER == IDX_W'(1)) begin
                    o_ERR     <= 1'b1;
                    state     <= FLUSH;
                    o_ARREADY <= 1'b0;
                end else begin
                    o_ERR     <= (state == RECV);
                    state     <= RECV;
                    o_ARREADY <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        o_ARREADY <= 1'b1;
                    end
                    RECV: begin
                        if (accept) begin
                            bin_cnt <= bin_cnt + IDX_W'(1);
                            if (i_ARBURST == BURST_LAST || bin_cnt == n_last) begin
                                o_ERR     <= o_ERR || (i_ARBURST != BURST_LAST) ||
                                             (bin_cnt != n_last);
                                state     <= FLUSH;
                                o_ARREADY <= 1'b0;
                            end
                        end
                    end
                    FLUSH: begin
                        if (!pipe_busy && !peak_stage_v) begin
                            o_DONE       <= 1'b1;
                            o_BUSY       <= 1'b0;
                            o_ARREADY    <= 1'b1;
                            o_PEAK_INDEX <= pk_idx;
                            o_PEAK_MAG   <= pk_mag;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector: one instance with the default search window, one searching every bin.
module tb_fft_peak_detector;
    import fft_axi_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] ardata;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [11:0] samples;

    logic        ready_a, done_a, err_a, busy_a;
    logic [11:0] idx_a;
    logic [32:0] mag_a;
    pd_state_t   state_a;
    logic        ready_b, done_b, err_b, busy_b;
    logic [11:0] idx_b;
    logic [32:0] mag_b;
    pd_state_t   state_b;

    int checks = 0;
    int errors = 0;
    int bre[16];
    int bim[16];

    fft_peak_detector dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_ARDATA(ardata), .i_ARVALID(arvalid),
        .o_ARREADY(ready_a), .i_ARBURST(arburst), .i_SAMPLES_NUMBER(samples),
        .o_PEAK_INDEX(idx_a), .o_PEAK_MAG(mag_a), .o_DONE(done_a), .o_ERR(err_a),
        .o_BUSY(busy_a), .o_dbg_state(state_a)
    );

    fft_peak_detector #(.SKIP_DC(1'b0), .HALF_SPEC(1'b0)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_ARDATA(ardata), .i_ARVALID(arvalid),
        .o_ARREADY(ready_b), .i_ARBURST(arburst), .i_SAMPLES_NUMBER(samples),
        .o_PEAK_INDEX(idx_b), .o_PEAK_MAG(mag_b), .o_DONE(done_b), .o_ERR(err_b),
        .o_BUSY(busy_b), .o_dbg_state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int re, input int im, input logic [1:0] burst);
        cplx_bin_t b;
        b.re    = 16'(re);
        b.im    = 16'(im);
        ardata  = b;
        arburst = burst;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            ardata  = $urandom;
            arburst = 2'($urandom_range(3));
            arvalid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic set_bin(input int i, input int re, input int im);
        bre[i] = re;
        bim[i] = im;
    endtask

    task automatic send_frame(input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps) idle_cycles(int'($urandom_range(2)));
            beat(bre[i], bim[i], (i == 0) ? BURST_FIRST :
                                 ((i == count - 1) ? BURST_LAST : BURST_MID));
        end
    endtask

    // Counts falling edges after the closing beat until o_DONE shows; 0 if it never does.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_a) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic void model_peak(input int n, input bit skip, input bit half,
                                       output int pidx, output longint pmag);
        pidx = 0;
        pmag = 0;
        for (int k = 0; k < n; k++) begin
            longint m;
            m = longint'(bre[k]) * bre[k] + longint'(bim[k]) * bim[k];
            if ((!skip || k != 0) && (!half || k < n / 2) && m > pmag) begin
                pmag = m;
                pidx = k;
            end
        end
    endfunction

    initial begin
        int     lat;
        int     pulses;
        int     m_idx;
        longint m_mag;

        rstn    = 1'b0;
        ardata  = '0;
        arvalid = 1'b0;
        arburst = BURST_MID;
        samples = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_state", 64'(state_a), 64'(IDLE));
        check("rst_peak", 64'(mag_b), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(ready_a), 64'd1);

        // 1: ramp on re, N=8
        samples = 12'd8;
        for (int k = 0; k < 8; k++) set_bin(k, k, 0);
        send_frame(8, 1'b0);
        check("t1_flush_ready", 64'(ready_a), 64'd0);
        check("t1_flush_state", 64'(state_a), 64'(FLUSH));
        check("t1_busy", 64'(busy_a), 64'd1);
        wait_done(lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_done_b", 64'(done_b), 64'd1);
        check("t1_idx_a", 64'(idx_a), 64'd3);
        check("t1_mag_a", 64'(mag_a), 64'd9);
        check("t1_idx_b", 64'(idx_b), 64'd7);
        check("t1_mag_b", 64'(mag_b), 64'd49);
        check("t1_err", 64'(err_a), 64'd0);
        check("t1_busy_done", 64'(busy_a), 64'd0);
        @(negedge clk);
        check("t1_done_pulse", 64'(done_a), 64'd0);
        check("t1_hold_idx", 64'(idx_a), 64'd3);

        // 2: tie between bin 0 and bin 1
        samples = 12'd4;
        set_bin(0, 100, 0);
        set_bin(1, 0, -100);
        set_bin(2, 3, 4);
        set_bin(3, 1, 1);
        send_frame(4, 1'b0);
        wait_done(lat);
        check("t2_latency", 64'(lat), 64'd4);
        check("t2_idx_b", 64'(idx_b), 64'd0);
        check("t2_mag_b", 64'(mag_b), 64'd10000);
        check("t2_idx_a", 64'(idx_a), 64'd1);
        check("t2_mag_a", 64'(mag_a), 64'd10000);

        // 3: LAST on the 5th beat of an 8-bin frame
        samples = 12'd8;
        for (int k = 0; k < 5; k++) set_bin(k, 10 * (k + 1), 0);
        send_frame(5, 1'b0);
        wait_done(lat);
        check("t3_latency", 64'(lat), 64'd4);
        check("t3_err_a", 64'(err_a), 64'd1);
        check("t3_err_b", 64'(err_b), 64'd1);
        check("t3_idx_a", 64'(idx_a), 64'd3);
        check("t3_mag_a", 64'(mag_a), 64'd1600);
        check("t3_idx_b", 64'(idx_b), 64'd4);
        check("t3_mag_b", 64'(mag_b), 64'd2500);
        @(negedge clk);
        check("t3_err_sticky", 64'(err_a), 64'd1);

        // next FIRST clears the error flag
        samples = 12'd4;
        beat(0, 5, BURST_FIRST);
        check("t3_err_cleared", 64'(err_a), 64'd0);
        beat(7, 0, BURST_MID);
        beat(0, -9, BURST_MID);
        beat(2, 2, BURST_LAST);
        wait_done(lat);
        check("t3b_idx_a", 64'(idx_a), 64'd1);
        check("t3b_mag_a", 64'(mag_a), 64'd49);
        check("t3b_idx_b", 64'(idx_b), 64'd2);
        check("t3b_mag_b", 64'(mag_b), 64'd81);
        check("t3b_err", 64'(err_b), 64'd0);

        // 4: single-bin ONLY frame at the most negative input
        samples = 12'd1;
        beat(-32768, -32768, BURST_ONLY);
        check("t4_flush_state", 64'(state_b), 64'(FLUSH));
        wait_done(lat);
        check("t4_latency", 64'(lat), 64'd4);
        check("t4_mag_b", 64'(mag_b), 64'h0_8000_0000);
        check("t4_idx_b", 64'(idx_b), 64'd0);
        check("t4_mag_a", 64'(mag_a), 64'd0);
        check("t4_idx_a", 64'(idx_a), 64'd0);
        check("t4_err", 64'(err_b), 64'd0);

        // 5: reset while bin 3 of 16 is on the bus
        samples = 12'd16;
        beat(500, 0, BURST_FIRST);
        beat(400, 0, BURST_MID);
        beat(300, 0, BURST_MID);
        ardata  = 32'h0100_0000;
        arburst = BURST_MID;
        arvalid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("t5_ready", 64'(ready_a), 64'd0);
        check("t5_busy", 64'(busy_a), 64'd0);
        check("t5_err_done", 64'({err_a, done_a, err_b, done_b}), 64'd0);
        check("t5_peak_a", 64'({idx_a, mag_a}), 64'd0);
        check("t5_peak_b", 64'({idx_b, mag_b}), 64'd0);
        check("t5_state", 64'(state_b), 64'(IDLE));
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_a || done_b) pulses++;
        end
        check("t5_no_done", 64'(pulses), 64'd0);
        samples = 12'd4;
        set_bin(0, 1, 0);
        set_bin(1, 0, 3);
        set_bin(2, 2, 2);
        set_bin(3, 5, 0);
        send_frame(4, 1'b0);
        wait_done(lat);
        check("t5_latency", 64'(lat), 64'd4);
        check("t5_idx_a", 64'(idx_a), 64'd1);
        check("t5_mag_a", 64'(mag_a), 64'd9);
        check("t5_idx_b", 64'(idx_b), 64'd3);
        check("t5_mag_b", 64'(mag_b), 64'd25);

        // 6: stray beats in IDLE, then a gappy 16-bin frame
        beat(30000, 0, BURST_MID);
        beat(0, -30000, BURST_LAST);
        beat(123, 0, BURST_MID);
        check("t6_stray_busy", 64'(busy_a), 64'd0);
        check("t6_stray_state", 64'(state_a), 64'(IDLE));
        samples = 12'd16;
        for (int k = 0; k < 16; k++)
            set_bin(k, int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000);
        send_frame(16, 1'b1);
        wait_done(lat);
        check("t6_latency", 64'(lat), 64'd4);
        model_peak(16, 1'b1, 1'b1, m_idx, m_mag);
        check("t6_idx_a", 64'(idx_a), 64'(m_idx));
        check("t6_mag_a", 64'(mag_a), 64'(m_mag));
        model_peak(16, 1'b0, 1'b0, m_idx, m_mag);
        check("t6_idx_b", 64'(idx_b), 64'(m_idx));
        check("t6_mag_b", 64'(mag_b), 64'(m_mag));
        check("t6_err", 64'(err_a), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
